delay_line_mc: RTL and testbench

//  Multi-channel programmable sample delay for the DSP datapath. NCH parallel

---
 rtl/delay_line_mc.sv | 113 +++++++++++
 tb/tb_delay_line_mc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_mc.sv
// Multi-channel programmable sample delay: a shared circular buffer written once per strobe,
// with one read tap per channel at (wr_ptr - dly[c]) and registered outputs.
module delay_line_mc #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NCH     = 4,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned DLY_W   = 8,
  parameter int unsigned DLY_RST = 0,
  localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [NCH*WIDTH-1:0] in_dat,
  input  logic                 wr_comm,
  input  logic                 cfg_all,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [DLY_W-1:0]     cfg_dly,
  output logic                 out_valid,
  output logic [NCH*WIDTH-1:0] out_dat,
  output logic [NCH-1:0]       out_ok,
  output logic                 cfg_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DLY_MAX  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] DLY_INIT = AW'(DLY_RST);

  logic [NCH*WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        fill_cnt_q;
  logic [AW-1:0]        dly_q [NCH];
  logic                 out_valid_q;
  logic [NCH*WIDTH-1:0] out_dat_q, out_dat_d;
  logic [NCH-1:0]       out_ok_q, out_ok_d;
  logic                 cfg_err_q;

  logic                 cfg_clamp;
  logic                 cfg_tgt_ok;
  logic [AW-1:0]        cfg_val;

  assign cfg_clamp  = 32'(cfg_dly) >= DEPTH;
  assign cfg_tgt_ok = cfg_all || (int'(cfg_ch) < NCH);
  assign cfg_val    = cfg_clamp ? DLY_MAX : AW'(cfg_dly);

  // Buffer contents are never reset; out_ok masks anything not yet written since reset.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[wr_ptr_q] <= in_dat;
    end
  end

  always_comb begin
    logic [AW-1:0] rd_addr;
    rd_addr   = '0;
    out_dat_d = '0;
    out_ok_d  = '0;
    for (int c = 0; c < NCH; c++) begin
      rd_addr     = wr_ptr_q - dly_q[c];
      out_ok_d[c] = fill_cnt_q >= dly_q[c];
      if (out_ok_d[c]) begin
        // Zero delay means the sample being written now, so bypass the array.
        if (dly_q[c] == '0) begin
          out_dat_d[c*WIDTH +: WIDTH] = in_dat[c*WIDTH +: WIDTH];
        end else begin
          out_dat_d[c*WIDTH +: WIDTH] = mem[rd_addr][c*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_dat_q   <= '0;
      out_ok_q    <= '0;
      cfg_err_q   <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        dly_q[c] <= DLY_INIT;
      end
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        wr_ptr_q  <= wr_ptr_q + AW'(1);
        out_dat_q <= out_dat_d;
        out_ok_q  <= out_ok_d;
        if (fill_cnt_q != DLY_MAX) begin
          fill_cnt_q <= fill_cnt_q + AW'(1);
        end
      end
      // A write in the same cycle as a strobe lands after that sample's read.
      if (wr_comm) begin
        for (int c = 0; c < NCH; c++) begin
          if (cfg_all || (int'(cfg_ch) == c)) begin
            dly_q[c] <= cfg_val;
          end
        end
        if (cfg_clamp && cfg_tgt_ok) begin
          cfg_err_q <= 1'b1;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_dat   = out_dat_q;
  assign out_ok    = out_ok_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_delay_line_mc.sv
// Self-checking bench for delay_line_mc: vector table, directed corner sequences and a
// random stream, all compared against a sample-history reference model.
module tb_delay_line_mc;

  localparam int W = 32;
  localparam int N = 4;
  localparam int D = 64;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, wr_comm, cfg_all;
  logic [127:0] in_dat;
  logic [1:0]   cfg_ch;
  logic [7:0]   cfg_dly;
  logic         out_valid, cfg_err;
  logic [127:0] out_dat;
  logic [3:0]   out_ok;

  delay_line_mc #(.WIDTH(32), .NCH(4), .DEPTH(64), .DLY_W(8), .DLY_RST(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_dat(in_dat), .wr_comm(wr_comm),
    .cfg_all(cfg_all), .cfg_ch(cfg_ch), .cfg_dly(cfg_dly), .out_valid(out_valid),
    .out_dat(out_dat), .out_ok(out_ok), .cfg_err(cfg_err)
  );

  // Three-channel instance so that an out-of-range cfg_ch is expressible.
  logic        s_rst, s_valid, s_wr, s_all, s_ovalid, s_err;
  logic [23:0] s_dat, s_odat;
  logic [1:0]  s_ch;
  logic [7:0]  s_dly;
  logic [2:0]  s_ok;

  delay_line_mc #(.WIDTH(8), .NCH(3), .DEPTH(8), .DLY_W(8), .DLY_RST(0)) u_dut3 (
    .clk(clk), .rst(s_rst), .in_valid(s_valid), .in_dat(s_dat), .wr_comm(s_wr),
    .cfg_all(s_all), .cfg_ch(s_ch), .cfg_dly(s_dly), .out_valid(s_ovalid),
    .out_dat(s_odat), .out_ok(s_ok), .cfg_err(s_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: full history of samples since reset plus the current delays.
  logic [127:0] hist[$];
  int           m_dly[N];
  logic         m_err, m_valid;
  logic [127:0] m_dat;
  logic [3:0]   m_ok;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pat(input int n);
    logic [127:0] r;
    for (int c = 0; c < N; c++) r[c*W +: W] = 32'((c << 16) | n);
    return r;
  endfunction

  task automatic step(input logic r, input logic v, input logic [127:0] d, input logic w,
                      input logic a, input logic [1:0] ch, input logic [7:0] dl);
    rst = r; in_valid = v; in_dat = d; wr_comm = w; cfg_all = a; cfg_ch = ch; cfg_dly = dl;
    if (r) begin
      hist.delete();
      for (int c = 0; c < N; c++) m_dly[c] = 0;
      m_err = 1'b0; m_valid = 1'b0; m_dat = '0; m_ok = '0;
    end else begin
      m_valid = v;
      if (v) begin
        int n;
        int fill;
        logic [127:0] old;
        n = hist.size();
        hist.push_back(d);
        fill = (n < D - 1) ? n : D - 1;
        for (int c = 0; c < N; c++) begin
          m_ok[c] = fill >= m_dly[c];
          m_dat[c*W +: W] = '0;
          if (m_ok[c]) begin
            old = hist[n - m_dly[c]];
            m_dat[c*W +: W] = old[c*W +: W];
          end
        end
      end
      if (w) begin
        for (int c = 0; c < N; c++) begin
          if (a || int'(ch) == c) begin
            m_dly[c] = (dl >= D) ? D - 1 : int'(dl);
            if (dl >= D) m_err = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 128'(out_valid), 128'(m_valid));
    chk("out_dat", out_dat, m_dat);
    chk("out_ok", 128'(out_ok), 128'(m_ok));
    chk("cfg_err", 128'(cfg_err), 128'(m_err));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 2'd0, 8'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 2'd0, 8'd0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 2'd0, 8'd0);
  endtask

  task automatic set_dly(input logic [1:0] ch, input logic [7:0] dl);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, ch, dl);
  endtask

  typedef struct {
    logic         v;
    logic [127:0] d;
    logic         w;
    logic         a;
    logic [1:0]   ch;
    logic [7:0]   dl;
    logic         ev;
    logic [3:0]   eok;
    logic         eerr;
    logic [127:0] edat;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b0, '0,     1'b1, 1'b0, 2'd1, 8'd2,   1'b0, 4'b0000, 1'b0, '0};
    tbl[1] = '{1'b1, pat(0), 1'b0, 1'b0, 2'd0, 8'd0,   1'b1, 4'b1101, 1'b0,
               {32'h30000, 32'h20000, 32'h0, 32'h0}};
    tbl[2] = '{1'b0, '0,     1'b0, 1'b0, 2'd0, 8'd0,   1'b0, 4'b1101, 1'b0,
               {32'h30000, 32'h20000, 32'h0, 32'h0}};
    tbl[3] = '{1'b1, pat(1), 1'b0, 1'b0, 2'd0, 8'd0,   1'b1, 4'b1101, 1'b0,
               {32'h30001, 32'h20001, 32'h0, 32'h1}};
    tbl[4] = '{1'b1, pat(2), 1'b0, 1'b0, 2'd0, 8'd0,   1'b1, 4'b1111, 1'b0,
               {32'h30002, 32'h20002, 32'h10000, 32'h2}};
    tbl[5] = '{1'b0, '0,     1'b1, 1'b1, 2'd0, 8'd200, 1'b0, 4'b1111, 1'b1,
               {32'h30002, 32'h20002, 32'h10000, 32'h2}};
    tbl[6] = '{1'b1, pat(3), 1'b0, 1'b0, 2'd0, 8'd0,   1'b1, 4'b0000, 1'b1, '0};
    tbl[7] = '{1'b0, '0,     1'b1, 1'b0, 2'd0, 8'd3,   1'b0, 4'b0000, 1'b1, '0};
    tbl[8] = '{1'b1, pat(4), 1'b0, 1'b0, 2'd0, 8'd0,   1'b1, 4'b0001, 1'b1,
               {32'h0, 32'h0, 32'h0, 32'h1}};

    s_rst = 1'b1; s_valid = 1'b0; s_wr = 1'b0; s_all = 1'b0; s_dat = '0; s_ch = '0; s_dly = '0;

    // Reset state, then the vector table (delay changes and clamping).
    do_reset();
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_ok", 128'(out_ok), 128'(0));
    chk("rst_dat", out_dat, 128'(0));
    for (int i = 0; i < 9; i++) begin
      step(1'b0, tbl[i].v, tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].ch, tbl[i].dl);
      chk($sformatf("tbl%0d_valid", i), 128'(out_valid), 128'(tbl[i].ev));
      chk($sformatf("tbl%0d_ok", i), 128'(out_ok), 128'(tbl[i].eok));
      chk($sformatf("tbl%0d_err", i), 128'(cfg_err), 128'(tbl[i].eerr));
      chk($sformatf("tbl%0d_dat", i), out_dat, tbl[i].edat);
    end

    // Full-rate stream with delays {0,1,5,63}.
    do_reset();
    chk("rst_clears_err", 128'(cfg_err), 128'(0));
    set_dly(2'd1, 8'd1); set_dly(2'd2, 8'd5); set_dly(2'd3, 8'd63);
    for (int n = 0; n < 140; n++) begin
      step(1'b0, 1'b1, pat(n), 1'b0, 1'b0, 2'd0, 8'd0);
      chk("ch0_bypass", 128'(out_dat[31:0]), 128'(n));
      if (n == 62) chk("ch3_ok_n62", 128'(out_ok[3]), 128'(0));
      if (n == 63) begin
        chk("ch3_ok_n63", 128'(out_ok[3]), 128'(1));
        chk("ch3_dat_n63", 128'(out_dat[127:96]), 128'(32'h30000));
      end
    end

    // Strobe every third clock, dly[1]=2, dly[2] 4 -> 10 at sample 20.
    do_reset();
    set_dly(2'd1, 8'd2); set_dly(2'd2, 8'd4);
    for (int n = 0; n < 30; n++) begin
      step(1'b0, 1'b1, pat(n), n == 20, 1'b0, 2'd2, 8'd10);
      if (n >= 2) chk("ch1_n_minus_2", 128'(out_dat[63:32]), 128'(32'h10000 | (n - 2)));
      if (n == 20) chk("ch2_old_dly", 128'(out_dat[95:64]), 128'(32'h20010));
      if (n == 21) begin
        chk("ch2_new_dly", 128'(out_dat[95:64]), 128'(32'h2000b));
        chk("ch2_ok_kept", 128'(out_ok[2]), 128'(1));
      end
      idle();
      idle();
    end

    // dly=40 over 300 samples so the write pointer wraps several times.
    do_reset();
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 2'd0, 8'd40);
    for (int n = 0; n < 300; n++) begin
      step(1'b0, 1'b1, pat(n), 1'b0, 1'b0, 2'd0, 8'd0);
      if (n >= 40) chk("wrap_ch1", 128'(out_dat[63:32]), 128'(32'h10000 | (n - 40)));
    end

    // Reset in mid-stream with the strobe held high.
    step(1'b1, 1'b1, pat(300), 1'b0, 1'b0, 2'd0, 8'd0);
    chk("midrst_dat", out_dat, 128'(0));
    chk("midrst_ok", 128'(out_ok), 128'(0));
    step(1'b0, 1'b1, pat(7), 1'b0, 1'b0, 2'd0, 8'd0);
    chk("postrst_ok", 128'(out_ok), 128'(4'hf));
    chk("postrst_dat", out_dat, pat(7));
    set_dly(2'd3, 8'd3);
    for (int n = 1; n < 6; n++) begin
      step(1'b0, 1'b1, pat(n + 7), 1'b0, 1'b0, 2'd0, 8'd0);
      chk("postrst_ok3", 128'(out_ok[3]), 128'(n >= 3));
    end

    // Random stream with random control traffic and occasional resets.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic v, w, a, r;
      logic [7:0] dl;
      r  = ($urandom % 250) == 0;
      v  = ($urandom % 3) != 0;
      w  = ($urandom % 12) == 0;
      a  = ($urandom % 4) == 0;
      dl = ($urandom % 2) ? 8'($urandom % 64) : 8'($urandom);
      step(r, v, {$urandom, $urandom, $urandom, $urandom}, w, a, 2'($urandom), dl);
    end

    // Out-of-range channel select on the three-channel instance.
    @(posedge clk); #1;
    s_rst = 1'b0; s_wr = 1'b1; s_ch = 2'd3; s_dly = 8'd5;
    @(posedge clk); #1;
    s_wr = 1'b0; s_valid = 1'b1; s_dat = 24'h030201;
    @(posedge clk); #1;
    chk("nch3_ok", 128'(s_ok), 128'(3'b111));
    chk("nch3_dat", 128'(s_odat), 128'(24'h030201));
    s_valid = 1'b0; s_wr = 1'b1; s_ch = 2'd3; s_dly = 8'd20;
    @(posedge clk); #1;
    chk("nch3_ignored_err", 128'(s_err), 128'(0));
    s_ch = 2'd1;
    @(posedge clk); #1;
    chk("nch3_clamp_err", 128'(s_err), 128'(1));
    s_wr = 1'b0; s_valid = 1'b1; s_dat = 24'h030202;
    @(posedge clk); #1;
    chk("nch3_ok_after", 128'(s_ok), 128'(3'b101));
    chk("nch3_dat_after", 128'(s_odat), 128'(24'h030002));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
